// File: rtl/morph_filter_if.sv
// Pixel stream bundle for morph_filter: upstream pixel/valid/SOF/mode in,
// filtered pixel stream plus frame markers and the abort pulse out.
interface morph_filter_if;
  logic       iDVAL;
  logic       iDATA;
  logic       iSOF;
  logic [1:0] iMODE;
  logic       oREADY;
  logic       oDVAL;
  logic       oDATA;
  logic       oSOF;
  logic       oEOF;
  logic       oABORT;

  // Handshake: a pixel transfers on a rising edge where iDVAL & oREADY; upstream
  // holds iDATA/iSOF/iMODE steady while iDVAL is high and oREADY is low.
  // oDVAL is a one-cycle qualifier with no back-pressure from downstream.
  modport master (
    output iDVAL, iDATA, iSOF, iMODE,
    input  oREADY, oDVAL, oDATA, oSOF, oEOF, oABORT
  );

  modport slave (
    input  iDVAL, iDATA, iSOF, iMODE,
    output oREADY, oDVAL, oDATA, oSOF, oEOF, oABORT
  );
endinterface

// File: rtl/morph_filter.sv
// Binary K x K morphological filter (bypass/erode/dilate/majority) on a raster
// pixel stream, using K-1 line buffers and a sliding window register.
module morph_filter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  morph_filter_if.slave bus,
  output logic [1:0]    dbg_state
);

  localparam int R  = (K - 1) / 2;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_R    = XW'(R);
  localparam logic [YW-1:0] Y_R    = YW'(R);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   in_x, ox, pos_x;
  logic [YW-1:0]   in_y, oy;
  logic [1:0]      mode_q;
  logic            acc, sof_acc, advance, emit, restart, abort_d;
  logic            fill_done, in_last, o_last, filt;
  logic [IMG_W-1:0] lb [K-1];
  logic [K-1:0]    col;
  logic [K-1:0]    win    [K];
  logic [K-1:0]    win_nx [K];

  assign bus.oREADY = (state_q != FLUSH);
  assign acc        = bus.iDVAL & bus.oREADY;
  assign sof_acc    = acc & bus.iSOF;
  assign fill_done  = (in_x == X_R) && (in_y == Y_R);
  assign in_last    = (in_x == X_LAST) && (in_y == Y_LAST);
  assign o_last     = (ox == X_LAST) && (oy == Y_LAST);
  assign dbg_state  = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    emit    = 1'b0;
    restart = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_acc) begin
          restart = 1'b1;
          advance = 1'b1;
          state_d = FILL;
        end
      end
      FILL, RUN: begin
        if (sof_acc) begin
          restart = 1'b1;
          advance = 1'b1;
          abort_d = 1'b1;
          state_d = FILL;
        end else if (acc) begin
          advance = 1'b1;
          if (state_q == RUN) begin
            emit = 1'b1;
            if (in_last) state_d = FLUSH;
          end else if (fill_done) begin
            emit    = 1'b1;
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        // Virtual pixels below the frame keep the window sliding; their row is masked.
        advance = 1'b1;
        emit    = 1'b1;
        if (o_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pos_x = restart ? '0 : in_x;

  always_comb begin
    col[0] = (state_q == FLUSH) ? 1'b0 : bus.iDATA;
    for (int j = 1; j < K; j++) col[j] = lb[j-1][pos_x];
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (c < K - 1) win_nx[r][c] = win[r][c+1];
        else           win_nx[r][c] = col[r];
      end
    end
  end

  // win_nx[r][c] sits at (ox + c - R, oy + R - r); anything outside the frame,
  // including wrapped columns of the neighbouring line, takes the mode's pad value.
  always_comb begin
    int  tx, ty, ones;
    logic tap;
    ones = 0;
    tx   = 0;
    ty   = 0;
    tap  = 1'b0;
    filt = 1'b0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        tx = int'(ox) + c - R;
        ty = int'(oy) + R - r;
        if (tx >= 0 && tx < IMG_W && ty >= 0 && ty < IMG_H) tap = win_nx[r][c];
        else                                                tap = (mode_q == 2'b01);
        if (tap) ones = ones + 1;
      end
    end
    case (mode_q)
      2'b00:   filt = win_nx[R][R];
      2'b01:   filt = (ones == K * K);
      2'b10:   filt = (ones != 0);
      default: filt = (ones >= (K * K + 1) / 2);
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_x       <= '0;
      in_y       <= '0;
      ox         <= '0;
      oy         <= '0;
      mode_q     <= 2'b00;
      bus.oDVAL  <= 1'b0;
      bus.oDATA  <= 1'b0;
      bus.oSOF   <= 1'b0;
      bus.oEOF   <= 1'b0;
      bus.oABORT <= 1'b0;
      for (int r = 0; r < K; r++) win[r] <= '0;
    end else begin
      bus.oDVAL  <= emit;
      bus.oDATA  <= emit & filt;
      bus.oSOF   <= emit && (ox == '0) && (oy == '0);
      bus.oEOF   <= emit && o_last;
      bus.oABORT <= abort_d;
      if (restart) begin
        mode_q <= bus.iMODE;
        ox     <= '0;
        oy     <= '0;
      end
      if (advance) begin
        win <= win_nx;
        if (pos_x == X_LAST) begin
          in_x <= '0;
          if (restart || in_y == Y_LAST) in_y <= '0;
          else                           in_y <= in_y + 1'b1;
        end else begin
          in_x <= pos_x + 1'b1;
          if (restart) in_y <= '0;
        end
      end
      if (emit) begin
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

  // Line buffers hold stale data after reset; only in-frame rows are ever used.
  always_ff @(posedge CLK) begin
    if (advance) begin
      lb[0][pos_x] <= col[0];
      for (int j = 1; j < K - 1; j++) lb[j][pos_x] <= lb[j-1][pos_x];
    end
  end

endmodule
